traffic_lamp_monitor: RTL and testbench
=======================================

# traffic_lamp_monitor

Receiving end of the controller's `La`/`Lb` lamp-code interface. The block registers both approach codes, decodes them into one-hot red/yellow/green lamp drives and checks every change against the legal traffic sequence, the mutual-exclusion rule and the minimum dwell times. On any violation it latches a fault code and forces both approaches to flashing red until software clears it. It sits between the traffic light controller and the lamp power stage.

## Interface
- `MIN_GREEN`, 4: minimum cycles a code of green (00) must be held before changing; 1..255.
- `MIN_YELLOW`, 2: minimum cycles a code of yellow (01) must be held before changing; 1..255.
- `FLASH_DIV`, 8: cycles per flash half-period in FAULT; 1..255.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset. Asynchronous and active-high.
- `la` in 2: approach A code. 00 green, 01 yellow, 10 red, 11 invalid.
- `lb` in 2: approach B code, same encoding.
- `clr` in 1: fault clear. Level-sampled; only honoured in FAULT.
- `lamp_a` out 3: approach A drive {R,Y,G}, one-hot or all-zero.
- `lamp_b` out 3: approach B drive, same format.
- `fault` out 1: high while in FAULT.
- `fault_code` out 3: latched cause. 0 none, 1 invalid code, 2 conflict, 3 illegal transition, 4 short dwell.

## Operation
- Input stage: `la`/`lb` are registered every edge into `la_q`/`lb_q`. All checks use `la_q`/`lb_q` and their previous values `la_p`/`lb_p`.
- States:
  - INIT: after reset or clear.
  - RUN: normal checking.
  - FAULT: latched failure.
- INIT:
  - Lamps are held at red.
  - Only the invalid and conflict checks are active.
  - After one clean edge the block goes to RUN. Both dwell counters are set to 1 and the baseline is taken from `la_q`/`lb_q`.
- RUN:
  - Lamps show the decoded `la_q`/`lb_q`.
  - Checks run on every edge, per approach unless noted:
    - Invalid: code is 11.
    - Conflict: neither approach is red. This is a cross-approach check.
    - Illegal transition: the code changed, and the change is not G→Y, Y→R or R→G.
    - Short dwell: the code changed from G with dwell < `MIN_GREEN`, or from Y with dwell < `MIN_YELLOW`.
  - Dwell counter:
    - 8-bit per approach.
    - Reloads to 1 on a code change and increments while the code is unchanged.
    - Saturates at 255 with no wrap.
- Priority when several checks fire on the same edge: invalid > conflict > illegal > short dwell. Approach A and approach B share one code, so only the highest-priority cause is latched.
- Detection from INIT or RUN goes to FAULT. It sets `fault`=1 and `fault_code`=cause, and clears the flash counter and the phase.
- FAULT:
  - Inputs are ignored and no new causes are latched.
  - Both lamps equal 100 in the lit phase and 000 in the dark phase.
  - The phase toggles every `FLASH_DIV` cycles, starting lit.
- `clr`=1 at an edge in FAULT moves the block to INIT. On that edge `fault`=0, `fault_code`=0 and lamps=100. `clr` in INIT or RUN has no effect.

## Timing
- Reset values:
  - state INIT
  - `lamp_a`=`lamp_b`=100
  - `fault`=0, `fault_code`=0
  - `la_q`=`lb_q`=10
  - dwell counters 0
  - flash counter 0
- Latency from an input code to lamp output is 2 edges: sample at edge N, output at edge N+1.
- A violating code sampled at edge N produces `fault`=1 and flashing lamps at edge N+1. The offending code is never displayed.
- The first flash half-period is `FLASH_DIV` full cycles after fault entry.
- `rst` mid-FAULT or mid-RUN returns all registers to reset values immediately, without waiting for a clock edge.
- A code held unchanged forever is legal. Saturated dwell always passes.

## Configuration
- Macro `TL_MON_DWELL_CHECK_EN`.
- Defined: the short-dwell check is active, and fault code 4 is reachable.
- Undefined:
  - No dwell counters are built and `MIN_GREEN`/`MIN_YELLOW` are unused.
  - Fault code 4 is never produced.
  - All other behaviour is identical.

## Test plan
- Legal cycle, with `MIN_GREEN`=4 and `MIN_YELLOW`=2:
  - Stimulus: `la`/`lb` = 00/10 for 5 cycles, 01/10 for 3, 10/00 for 5, 10/01 for 3, then 00/10.
  - Required: lamps follow 2 edges late (A=001 while B=100, and so on), and `fault` stays 0.
- Conflict: `la`=00, `lb`=01 sampled in RUN → one edge later `fault`=1, `fault_code`=2, both lamps=100.
- Illegal transition: A goes G→R after 6 cycles of green → `fault_code`=3.
- Short dwell and priority:
  - A goes G→Y after 2 cycles of green → `fault_code`=4. This case applies with the macro defined; with the macro undefined, no fault is raised.
  - `la`=11 while `lb`=00 → `fault_code`=1 (invalid outranks conflict).
- Flash, clear and reset:
  - With `FLASH_DIV`=8, lamps are 100 for 8 cycles, then 000 for 8, repeating.
  - `clr` pulsed in FAULT → INIT with `fault`=0 and lamps 100, then RUN after one clean edge.
  - `rst` asserted mid-flash → immediate reset values with no clock edge.

Source files
------------

// File: rtl/traffic_lamp_monitor.sv
// traffic_lamp_monitor: registers the La/Lb lamp codes, drives one-hot lamps and latches
// sequence/exclusion/dwell faults into flashing red. Macro TL_MON_DWELL_CHECK_EN enables the dwell check.
module traffic_lamp_monitor #(
  parameter int unsigned MIN_GREEN  = 4,
  parameter int unsigned MIN_YELLOW = 2,
  parameter int unsigned FLASH_DIV  = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] la,
  input  logic [1:0] lb,
  input  logic       clr,
  output logic [2:0] lamp_a,
  output logic [2:0] lamp_b,
  output logic       fault,
  output logic [2:0] fault_code
);

  if (MIN_GREEN < 1 || MIN_GREEN > 255 || MIN_YELLOW < 1 || MIN_YELLOW > 255 ||
      FLASH_DIV < 1 || FLASH_DIV > 255) begin : g_param_check
    $error("traffic_lamp_monitor: MIN_GREEN/MIN_YELLOW/FLASH_DIV must be 1..255");
  end

  typedef enum logic [1:0] {S_INIT, S_RUN, S_FAULT} state_t;
  typedef enum logic [1:0] {CODE_G = 2'b00, CODE_Y = 2'b01, CODE_R = 2'b10, CODE_X = 2'b11} code_t;
  typedef enum logic [2:0] {
    C_NONE = 3'd0, C_INVALID = 3'd1, C_CONFLICT = 3'd2, C_ILLEGAL = 3'd3, C_DWELL = 3'd4
  } cause_t;

  localparam logic [2:0] LAMP_R     = 3'b100;
  localparam logic [2:0] LAMP_OFF   = 3'b000;
  localparam logic [7:0] FLASH_LAST = 8'(FLASH_DIV - 1);

  state_t     state, state_d;
  cause_t     cause;
  logic [1:0] la_q, lb_q, la_p, lb_p, la_p_d, lb_p_d;
  logic [2:0] lamp_a_d, lamp_b_d, code_d;
  logic       fault_d;
  logic [7:0] flash_cnt, flash_cnt_d;
  logic       dark, dark_d;
  logic       invalid, conflict, illegal, short_dwell;

  function automatic logic legal_step(input logic [1:0] prev, input logic [1:0] cur);
    return (prev == CODE_G && cur == CODE_Y) ||
           (prev == CODE_Y && cur == CODE_R) ||
           (prev == CODE_R && cur == CODE_G);
  endfunction

  function automatic logic [2:0] decode(input logic [1:0] code);
    case (code)
      CODE_G:  return 3'b001;
      CODE_Y:  return 3'b010;
      CODE_R:  return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  assign invalid  = (la_q == CODE_X) || (lb_q == CODE_X);
  assign conflict = (la_q != CODE_R) && (lb_q != CODE_R);
  assign illegal  = ((la_q != la_p) && !legal_step(la_p, la_q)) ||
                    ((lb_q != lb_p) && !legal_step(lb_p, lb_q));

`ifdef TL_MON_DWELL_CHECK_EN
  logic [7:0] dwell_a, dwell_b, dwell_a_d, dwell_b_d;

  function automatic logic too_short(input logic [1:0] prev, input logic [7:0] dwell);
    return (prev == CODE_G && dwell < 8'(MIN_GREEN)) ||
           (prev == CODE_Y && dwell < 8'(MIN_YELLOW));
  endfunction

  // Saturating count of edges the previous code has been held; reloads on change.
  function automatic logic [7:0] next_dwell(input logic changed, input logic [7:0] dwell);
    if (changed)
      return 8'd1;
    return (dwell == 8'hFF) ? dwell : dwell + 8'd1;
  endfunction

  assign short_dwell = ((la_q != la_p) && too_short(la_p, dwell_a)) ||
                       ((lb_q != lb_p) && too_short(lb_p, dwell_b));
`else
  assign short_dwell = 1'b0;
`endif

  // INIT only arms the invalid and conflict checks; the rest need a baseline.
  always_comb begin
    cause = C_NONE;
    if (invalid)
      cause = C_INVALID;
    else if (conflict)
      cause = C_CONFLICT;
    else if (state == S_RUN && illegal)
      cause = C_ILLEGAL;
    else if (state == S_RUN && short_dwell)
      cause = C_DWELL;
  end

  always_comb begin
    state_d     = state;
    la_p_d      = la_p;
    lb_p_d      = lb_p;
    lamp_a_d    = lamp_a;
    lamp_b_d    = lamp_b;
    fault_d     = fault;
    code_d      = fault_code;
    flash_cnt_d = flash_cnt;
    dark_d      = dark;
`ifdef TL_MON_DWELL_CHECK_EN
    dwell_a_d   = dwell_a;
    dwell_b_d   = dwell_b;
`endif
    case (state)
      S_INIT, S_RUN: begin
        if (cause != C_NONE) begin
          state_d     = S_FAULT;
          fault_d     = 1'b1;
          code_d      = cause;
          flash_cnt_d = '0;
          dark_d      = 1'b0;
          lamp_a_d    = LAMP_R;
          lamp_b_d    = LAMP_R;
        end else begin
          state_d = S_RUN;
          la_p_d  = la_q;
          lb_p_d  = lb_q;
          if (state == S_INIT) begin
            lamp_a_d = LAMP_R;
            lamp_b_d = LAMP_R;
`ifdef TL_MON_DWELL_CHECK_EN
            dwell_a_d = 8'd1;
            dwell_b_d = 8'd1;
`endif
          end else begin
            lamp_a_d = decode(la_q);
            lamp_b_d = decode(lb_q);
`ifdef TL_MON_DWELL_CHECK_EN
            dwell_a_d = next_dwell(la_q != la_p, dwell_a);
            dwell_b_d = next_dwell(lb_q != lb_p, dwell_b);
`endif
          end
        end
      end
      S_FAULT: begin
        if (clr) begin
          state_d     = S_INIT;
          fault_d     = 1'b0;
          code_d      = '0;
          flash_cnt_d = '0;
          dark_d      = 1'b0;
          lamp_a_d    = LAMP_R;
          lamp_b_d    = LAMP_R;
        end else begin
          if (flash_cnt == FLASH_LAST) begin
            flash_cnt_d = '0;
            dark_d      = ~dark;
          end else begin
            flash_cnt_d = flash_cnt + 8'd1;
          end
          lamp_a_d = dark_d ? LAMP_OFF : LAMP_R;
          lamp_b_d = dark_d ? LAMP_OFF : LAMP_R;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_INIT;
      la_q       <= CODE_R;
      lb_q       <= CODE_R;
      la_p       <= CODE_R;
      lb_p       <= CODE_R;
      lamp_a     <= LAMP_R;
      lamp_b     <= LAMP_R;
      fault      <= 1'b0;
      fault_code <= '0;
      flash_cnt  <= '0;
      dark       <= 1'b0;
`ifdef TL_MON_DWELL_CHECK_EN
      dwell_a    <= '0;
      dwell_b    <= '0;
`endif
    end else begin
      state      <= state_d;
      la_q       <= la;
      lb_q       <= lb;
      la_p       <= la_p_d;
      lb_p       <= lb_p_d;
      lamp_a     <= lamp_a_d;
      lamp_b     <= lamp_b_d;
      fault      <= fault_d;
      fault_code <= code_d;
      flash_cnt  <= flash_cnt_d;
      dark       <= dark_d;
`ifdef TL_MON_DWELL_CHECK_EN
      dwell_a    <= dwell_a_d;
      dwell_b    <= dwell_b_d;
`endif
    end
  end

endmodule

// File: tb/tb_traffic_lamp_monitor.sv
// Scoreboard bench for traffic_lamp_monitor: expected {lamp_a,lamp_b,fault,fault_code}
// is queued with its due edge when stimulus is driven and compared when that edge is reached.
module tb_traffic_lamp_monitor;

  localparam logic [2:0] R = 3'b100, Y = 3'b010, G = 3'b001, O = 3'b000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] la  = 2'b10;
  logic [1:0] lb  = 2'b10;
  logic       clr = 1'b0;
  logic [2:0] lamp_a, lamp_b, fault_code;
  logic       fault;
  logic [9:0] obs;

  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned passed = 0;

  typedef struct {
    int unsigned due;
    logic [9:0]  val;
  } exp_t;
  exp_t sb[$];

  traffic_lamp_monitor #(.MIN_GREEN(4), .MIN_YELLOW(2), .FLASH_DIV(8)) dut (
    .clk(clk), .rst(rst), .la(la), .lb(lb), .clr(clr),
    .lamp_a(lamp_a), .lamp_b(lamp_b), .fault(fault), .fault_code(fault_code)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign obs = {lamp_a, lamp_b, fault, fault_code};

  function automatic logic [2:0] lamp_of(input logic [1:0] code);
    case (code)
      2'b00:   return G;
      2'b01:   return Y;
      2'b10:   return R;
      default: return O;
    endcase
  endfunction

  function automatic logic [9:0] pack(input logic [2:0] a, input logic [2:0] b,
                                      input logic f, input logic [2:0] c);
    return {a, b, f, c};
  endfunction

  // n edges after fault entry: lit for 8 edges, dark for 8, repeating; cause stays conflict.
  function automatic logic [9:0] flash_conflict(input int unsigned n);
    return (((n / 8) % 2) == 0) ? pack(R, R, 1'b1, 3'd2) : pack(O, O, 1'b1, 3'd2);
  endfunction

  task automatic do_reset();
    rst = 1'b1; la = 2'b10; lb = 2'b10; clr = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; la = 2'b11; lb = 2'b11; clr = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (obs !== pack(R, R, 1'b0, 3'd0))
      $display("FAIL reset: got a=%b b=%b f=%b c=%0d, want a=100 b=100 f=0 c=0",
               lamp_a, lamp_b, fault, fault_code);
    else passed++;
  endtask

  task automatic test_legal_cycle();
    exp_t e;
    do_reset();
    for (int k = 0; k < 22; k++) begin
      if (k < 20) begin
        if (k < 2)       begin la = 2'b10; lb = 2'b10; end
        else if (k < 7)  begin la = 2'b00; lb = 2'b10; end
        else if (k < 10) begin la = 2'b01; lb = 2'b10; end
        else if (k < 15) begin la = 2'b10; lb = 2'b00; end
        else if (k < 18) begin la = 2'b10; lb = 2'b01; end
        else             begin la = 2'b00; lb = 2'b10; end
        sb.push_back('{due: cyc + 2, val: pack(lamp_of(la), lamp_of(lb), 1'b0, 3'd0)});
      end
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL legal_cycle k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_conflict();
    exp_t e;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      if (k < 6) begin
        if (k < 2)       begin la = 2'b10; lb = 2'b10; sb.push_back('{cyc + 2, pack(R, R, 1'b0, 3'd0)}); end
        else if (k == 2) begin la = 2'b00; lb = 2'b10; sb.push_back('{cyc + 2, pack(G, R, 1'b0, 3'd0)}); end
        else             begin la = 2'b00; lb = 2'b01; sb.push_back('{cyc + 2, pack(R, R, 1'b1, 3'd2)}); end
      end
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL conflict k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_illegal();
    exp_t e;
    do_reset();
    for (int k = 0; k < 12; k++) begin
      if (k < 10) begin
        if (k < 2)      begin la = 2'b10; lb = 2'b10; sb.push_back('{cyc + 2, pack(R, R, 1'b0, 3'd0)}); end
        else if (k < 8) begin la = 2'b00; lb = 2'b10; sb.push_back('{cyc + 2, pack(G, R, 1'b0, 3'd0)}); end
        else            begin la = 2'b10; lb = 2'b10; sb.push_back('{cyc + 2, pack(R, R, 1'b1, 3'd3)}); end
      end
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL illegal k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
  endtask

  task automatic test_invalid_priority();
    exp_t e;
    do_reset();
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        if (k < 2) begin la = 2'b10; lb = 2'b10; sb.push_back('{cyc + 2, pack(R, R, 1'b0, 3'd0)}); end
        else       begin la = 2'b11; lb = 2'b00; sb.push_back('{cyc + 2, pack(R, R, 1'b1, 3'd1)}); end
      end
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL invalid_priority k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
  endtask

  // Three phases: green held 2 (too short), green 4 then yellow 1 (boundary pass, then
  // yellow too short), green held 257 (saturated dwell must pass) then yellow 2.
  task automatic test_short_dwell();
    exp_t       e;
    int unsigned n;
    logic [9:0] short_fault;
    logic [9:0] want;
    for (int ph = 0; ph < 3; ph++) begin
      do_reset();
      n = (ph == 0) ? 6 : (ph == 1) ? 8 : 262;
      for (int unsigned k = 0; k < n + 2; k++) begin
        if (k < n) begin
          if (k < 2) begin
            la = 2'b10; lb = 2'b10; want = pack(R, R, 1'b0, 3'd0);
          end else if (ph == 0) begin
            la = (k < 4) ? 2'b00 : 2'b01; lb = 2'b10;
`ifdef TL_MON_DWELL_CHECK_EN
            short_fault = pack(R, R, 1'b1, 3'd4);
`else
            short_fault = pack(Y, R, 1'b0, 3'd0);
`endif
            want = (k < 4) ? pack(G, R, 1'b0, 3'd0) : short_fault;
          end else if (ph == 1) begin
            lb = 2'b10;
            if (k < 6)       begin la = 2'b00; want = pack(G, R, 1'b0, 3'd0); end
            else if (k == 6) begin la = 2'b01; want = pack(Y, R, 1'b0, 3'd0); end
            else begin
              la = 2'b10;
`ifdef TL_MON_DWELL_CHECK_EN
              want = pack(R, R, 1'b1, 3'd4);
`else
              want = pack(R, R, 1'b0, 3'd0);
`endif
            end
          end else begin
            lb = 2'b10;
            if (k < 259)      begin la = 2'b00; want = pack(G, R, 1'b0, 3'd0); end
            else if (k < 261) begin la = 2'b01; want = pack(Y, R, 1'b0, 3'd0); end
            else              begin la = 2'b10; want = pack(R, R, 1'b0, 3'd0); end
          end
          sb.push_back('{cyc + 2, want});
        end
        @(posedge clk); #1;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
          e = sb.pop_front();
          checks++;
          if (obs !== e.val)
            $display("FAIL short_dwell ph=%0d k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                     ph, k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
          else passed++;
        end
      end
    end
  endtask

  // Expectations here are for the very next edge, since clr acts without an input stage.
  task automatic test_flash_clear();
    exp_t       e;
    logic [9:0] want;
    do_reset();
    for (int unsigned k = 0; k < 28; k++) begin
      clr = 1'b0; la = 2'b10; lb = 2'b10;
      if (k < 2)        want = pack(R, R, 1'b0, 3'd0);
      else if (k < 22)  want = flash_conflict(k - 2);
      else if (k < 25)  want = pack(R, R, 1'b0, 3'd0);
      else              want = pack(G, R, 1'b0, 3'd0);
      if (k == 1) begin la = 2'b00; lb = 2'b01; end
      if (k == 22 || k == 26) clr = 1'b1;
      if (k == 24 || k == 25 || k == 26) la = 2'b00;
      if (k == 27) la = 2'b01;
      sb.push_back('{cyc + 1, want});
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL flash_clear k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
    clr = 1'b0;
  endtask

  task automatic test_async_reset();
    exp_t       e;
    logic [9:0] want;
    do_reset();
    for (int unsigned k = 0; k < 13; k++) begin
      la = 2'b10; lb = 2'b10;
      if (k == 1) begin la = 2'b00; lb = 2'b01; end
      want = (k < 2) ? pack(R, R, 1'b0, 3'd0) : flash_conflict(k - 2);
      sb.push_back('{cyc + 1, want});
      @(posedge clk); #1;
      while (sb.size() != 0 && sb[0].due <= cyc) begin
        e = sb.pop_front();
        checks++;
        if (obs !== e.val)
          $display("FAIL async_reset k=%0d: got a=%b b=%b f=%b c=%0d, want a=%b b=%b f=%b c=%0d",
                   k, lamp_a, lamp_b, fault, fault_code, e.val[9:7], e.val[6:4], e.val[3], e.val[2:0]);
        else passed++;
      end
    end
    // Dark phase now; reset must restore red lamps before any further clock edge.
    #1 rst = 1'b1;
    #2;
    checks++;
    if (obs !== pack(R, R, 1'b0, 3'd0))
      $display("FAIL async_reset immediate: got a=%b b=%b f=%b c=%0d, want a=100 b=100 f=0 c=0",
               lamp_a, lamp_b, fault, fault_code);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_legal_cycle();
    test_conflict();
    test_illegal();
    test_invalid_priority();
    test_short_dwell();
    test_flash_clear();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passed, checks);
    $fatal(1);
  end

endmodule
